piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter; the transmit-side counterpart of the team's SIPO receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clock on s_out, with s_valid framing and a last-bit marker.
- Sits upstream of the SIPO: s_out drives the receiver's s_in directly, same clock domain.

Parameters:
- WIDTH, 3: data word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- p_in  input  WIDTH  parallel word to transmit.
- p_valid  input  1  p_in is valid.
- p_ready  output  1  block can accept a word this cycle.
- s_out  output  1  serial data bit.
- s_valid  output  1  s_out carries a valid frame bit.
- s_last  output  1  current s_out is the final bit of the frame.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, s_out = 0, s_valid = 0, s_last = 0, busy = 0. p_ready is combinational and reads 1 while in reset-released IDLE.
- All outputs except p_ready are registered.
- States: IDLE, SHIFT, PARITY. PARITY exists only with the optional feature.
- Handshake: a word is accepted on a rising edge where p_valid && p_ready. p_in is sampled only at that edge. The sender may change p_in freely at other times.
- p_ready = (state == IDLE) || (state == SHIFT && count == WIDTH-1 && parity feature off). This lets a new word load on the last-bit cycle for gap-free streaming.
- Latency: the first bit appears on s_out in the cycle after acceptance (1-cycle latency).
- Frame length: s_valid is high for exactly WIDTH consecutive cycles per word. Add 1 cycle with parity.
- Bit order: MSB_FIRST=1 sends p_in[WIDTH-1] down to p_in[0]; MSB_FIRST=0 sends p_in[0] up to p_in[WIDTH-1].
- Counter: counts 0 … WIDTH-1 within SHIFT. s_last = 1 when count == WIDTH-1 (or in PARITY when the feature is on).
- IDLE → SHIFT on accept; count = 0.
- SHIFT: each edge advances one bit and increments count.
  - At count == WIDTH-1 with no new accept → IDLE.
  - At count == WIDTH-1 with a new accept → stay in SHIFT, reload, count = 0. No idle gap, s_valid stays high.
- IDLE outputs: s_out = 0, s_valid = 0, s_last = 0.
- p_valid while busy and not at the last bit: ignored. p_ready = 0 and the sender must hold the word.
- Reset mid-frame: the frame is aborted immediately (asynchronously), outputs go to reset values, and the partial frame is never resumed.
- Counter width = clog2(WIDTH) bits; no wrap beyond WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits the FSM enters PARITY for one cycle.
  - s_out = XOR of the accepted word (even parity), s_valid = 1, s_last = 1.
  - Data-bit s_last is suppressed, so s_last marks only the parity bit.
  - p_ready is high only in IDLE and PARITY. An accept in PARITY goes straight to SHIFT with no gap.
  - Frame = WIDTH+1 cycles.
- Undefined: the PARITY state and its logic are absent; frame = WIDTH cycles; p_ready as stated above.

Test Plan:
- Reset release, p_valid=0 for 5 cycles → s_valid=0, s_out=0, busy=0, p_ready=1 throughout.
- WIDTH=3, MSB_FIRST=1, accept p_in=3'b101 → next 3 cycles s_out = 1,0,1; s_valid=1 for 3 cycles; s_last=1 only on the 3rd; then back to IDLE.
- Back-to-back: 3'b110 accepted, p_valid held with 3'b011 → s_out = 1,1,0,0,1,1 with s_valid high for 6 contiguous cycles; second accept occurs on the first word's last-bit cycle.
- MSB_FIRST=0, p_in=3'b110 → s_out = 0,1,1. p_valid asserted mid-frame with 3'b111 → not accepted until p_ready=1.
- Reset asserted asynchronously between clock edges during bit 2 of 3'b101 → s_valid, busy and s_out drop to 0 immediately; after release, p_ready=1 and the next word 3'b010 transmits cleanly as 0,1,0.
- PISO_PARITY_EN: p_in=3'b110 → s_out = 1,1,0,0 (parity 0), s_last only on the 4th bit. p_in=3'b100 → s_out = 1,0,0,1 (parity 1).

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, valid/ready word input, framed serial output.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
  parameter int WIDTH = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  logic at_last, accept;
  assign at_last = state == SHIFT && cnt == LAST;
  assign accept = p_valid && p_ready;
`ifdef PISO_PARITY_EN
  localparam bit DATA_LAST = 1'b0;
  logic par;
  assign p_ready = state == IDLE || state == PARITY;
`else
  localparam bit DATA_LAST = 1'b1;
  assign p_ready = state == IDLE || at_last;
`endif
  // sh holds the bits still to be sent, next bit at the outgoing end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      s_out   <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      busy    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      cnt     <= '0;
      s_out   <= MSB_FIRST ? p_in[WIDTH-1] : p_in[0];
      sh      <= MSB_FIRST ? p_in << 1 : p_in >> 1;
      s_valid <= 1'b1;
      s_last  <= 1'b0;
      busy    <= 1'b1;
`ifdef PISO_PARITY_EN
      par     <= ^p_in;
`endif
    end else if (state == SHIFT && !at_last) begin
      cnt    <= cnt + 1'b1;
      s_out  <= MSB_FIRST ? sh[WIDTH-1] : sh[0];
      sh     <= MSB_FIRST ? sh << 1 : sh >> 1;
      s_last <= DATA_LAST && (cnt + 1'b1 == LAST);
    end
`ifdef PISO_PARITY_EN
    else if (at_last) begin
      state  <= PARITY;
      s_out  <= par;
      s_last <= 1'b1;
    end
`endif
    else begin
      state   <= IDLE;
      cnt     <= '0;
      s_out   <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      busy    <= 1'b0;
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: random and directed stimulus against a queue-of-bits frame model, both bit orders.
module tb_piso_tx;
  localparam int W = 3;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, p_valid = 1'b0, accepted = 1'b0;
  logic [W-1:0] p_in = '0;
  logic [1:0] p_ready, s_out, s_valid, s_last, busy;
  logic [1:0] q0[$], q1[$];
  logic [2:0] e0, e1;
  logic [2:0] o;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .p_in(p_in),
    .p_valid(p_valid), .p_ready(p_ready[0]), .s_out(s_out[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .busy(busy[0]));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .p_in(p_in),
    .p_valid(p_valid), .p_ready(p_ready[1]), .s_out(s_out[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is the list of {bit, last} pairs it will put on the wire, in order.
  task automatic load(input logic [W-1:0] w);
    q0.delete();
    q1.delete();
    for (int i = 0; i < W; i++) begin
      q0.push_back({w[W-1-i], !PAR && i == W - 1});
      q1.push_back({w[i], !PAR && i == W - 1});
    end
    if (PAR) begin
      q0.push_back({^w, 1'b1});
      q1.push_back({^w, 1'b1});
    end
  endtask

  task automatic check_out(input logic [2:0] x0, input logic [2:0] x1);
    check("s_valid_msb", s_valid[0], x0[2]);
    check("busy_msb", busy[0], x0[2]);
    check("s_out_msb", s_out[0], x0[1]);
    check("s_last_msb", s_last[0], x0[0]);
    check("s_valid_lsb", s_valid[1], x1[2]);
    check("busy_lsb", busy[1], x1[2]);
    check("s_out_lsb", s_out[1], x1[1]);
    check("s_last_lsb", s_last[1], x1[0]);
  endtask

  // Ready whenever nothing remains queued behind the bit currently on the wire.
  task automatic cycle();
    logic rdy;
    rdy = q0.size() == 0;
    check("p_ready_msb", p_ready[0], rdy);
    check("p_ready_lsb", p_ready[1], rdy);
    accepted = p_valid && rdy;
    @(posedge clk);
    if (accepted) load(p_in);
    if (q0.size() != 0) begin
      e0 = {1'b1, q0.pop_front()};
      e1 = {1'b1, q1.pop_front()};
    end else begin
      e0 = 3'b000;
      e1 = 3'b000;
    end
    #1;
    check_out(e0, e1);
  endtask

  task automatic send_until_accepted(input logic [W-1:0] w, input string tag);
    p_valid = 1'b1;
    p_in = w;
    accepted = 1'b0;
    for (int i = 0; i < 12 && !accepted; i++) cycle();
    check(tag, accepted, 1'b1);
    p_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_out(3'b000, 3'b000);
    reset = 1'b0;
    repeat (5) cycle();
    send_until_accepted(3'b101, "accept_101");
    o[2] = s_out[0];
    cycle();
    o[1] = s_out[0];
    cycle();
    o[0] = s_out[0];
    check("seq_101_msb", o, 3'b101);
    repeat (4) cycle();
    send_until_accepted(3'b110, "accept_110");
    send_until_accepted(3'b011, "accept_011_b2b");
    repeat (6) cycle();
    send_until_accepted(3'b110, "accept_110_b");
    send_until_accepted(3'b111, "accept_111_held");
    repeat (6) cycle();
    send_until_accepted(3'b101, "accept_101_rst");
    cycle();
    #2 reset = 1'b1;
    #1;
    check_out(3'b000, 3'b000);
    q0.delete();
    q1.delete();
    #1 reset = 1'b0;
    send_until_accepted(3'b010, "accept_010");
    o[2] = s_out[0];
    cycle();
    o[1] = s_out[0];
    cycle();
    o[0] = s_out[0];
    check("seq_010_msb", o, 3'b010);
    repeat (3) cycle();
    for (int n = 0; n < 400; n++) begin
      if (!p_valid || accepted) begin
        p_valid = $urandom_range(3) != 0;
        p_in = W'($urandom);
      end
      cycle();
    end
    p_valid = 1'b0;
    repeat (6) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
